// File: rtl/ram_bist_pkg.sv
// Shared state type and data-pattern helper for the RAM march-test controller.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StRdA,
    StWrB,
    StRdB,
    StDrain,
    StDone
  } state_e;

  localparam logic DirAsc  = 1'b0;
  localparam logic DirDesc = 1'b1;

  // Widest data word the pattern helper supports.
  localparam int unsigned MaxWidth = 64;

  function automatic logic phase_dir(input state_e st);
    return (st == StWrB || st == StRdB) ? DirDesc : DirAsc;
  endfunction

  // Pattern for one address: base pattern xor zero-extended address, optionally inverted.
  function automatic logic [MaxWidth-1:0] march_word(input logic [MaxWidth-1:0] pattern,
                                                     input logic [MaxWidth-1:0] addr,
                                                     input logic            inv);
    logic [MaxWidth-1:0] word;
    word = pattern ^ addr;
    return inv ? ~word : word;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read checker: lines expected data up with the one-cycle RAM read latency and
// latches address/expected/actual of the first mismatch.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             active_i,
  input  logic             rd_en_i,
  input  logic [DEPTH-1:0] addr_i,
  input  logic             inv_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             new_fail_o,
  output logic             err_o,
  output logic [DEPTH-1:0] fail_addr_o,
  output logic [WIDTH-1:0] fail_exp_o,
  output logic [WIDTH-1:0] fail_got_o
);

  logic [WIDTH-1:0] exp_now;

  // Stage 1: the read issued this cycle, compared when its data returns.
  logic             rd_vld_q;
  logic [DEPTH-1:0] rd_addr_q;
  logic [WIDTH-1:0] rd_exp_q;

  // Stage 2: first-fail capture.
  logic             err_q, err_d;
  logic [DEPTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [WIDTH-1:0] fail_got_q, fail_got_d;

  logic mismatch;

  assign exp_now = WIDTH'(march_word(MaxWidth'(PATTERN), MaxWidth'(addr_i), inv_i));

  assign mismatch   = active_i && rd_vld_q && (data_i != rd_exp_q);
  assign new_fail_o = mismatch && !err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_exp_q  <= '0;
    end else begin
      rd_vld_q  <= rd_en_i;
      rd_addr_q <= addr_i;
      rd_exp_q  <= exp_now;
    end
  end

  always_comb begin
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    if (clear_i) begin
      err_d       = 1'b0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_got_d  = '0;
    end else if (new_fail_o) begin
      err_d       = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_exp_d  = rd_exp_q;
      fail_got_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign err_o       = err_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator: write, read, write-inverse, read-inverse over every RAM word.
// Define RAM_BIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [DEPTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_got,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  input  logic [WIDTH-1:0] mem_data_out
);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             dir;
  logic             terminal;
  logic [DEPTH-1:0] addr_step;
  logic             start_ok;
  logic             new_fail;
  logic             err;

  function automatic logic [WIDTH-1:0] word(input logic [DEPTH-1:0] a, input logic inv);
    return WIDTH'(march_word(MaxWidth'(PATTERN), MaxWidth'(a), inv));
  endfunction

  assign dir       = phase_dir(state_q);
  assign addr_step = (dir == DirAsc) ? addr_q + DEPTH'(1) : addr_q - DEPTH'(1);
  assign terminal  = (dir == DirAsc) ? (addr_q == {DEPTH{1'b1}}) : (addr_q == '0);
  assign start_ok  = start && (state_q == StIdle || state_q == StDone);

  ram_bist_checker #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PATTERN(PATTERN)
  ) u_checker (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (start_ok),
    .active_i   (busy_q),
    .rd_en_i    (rd_q),
    .addr_i     (addr_q),
    .inv_i      (state_q == StRdB),
    .data_i     (mem_data_out),
    .new_fail_o (new_fail),
    .err_o      (err),
    .fail_addr_o(fail_addr),
    .fail_exp_o (fail_exp),
    .fail_got_o (fail_got)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = '0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StWrA;
          addr_d  = '0;
          wr_d    = 1'b1;
          data_d  = word('0, 1'b0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StWrA: begin
        busy_d = 1'b1;
        addr_d = addr_step;
        if (terminal) begin
          state_d = StRdA;
          rd_d    = 1'b1;
        end else begin
          wr_d   = 1'b1;
          data_d = word(addr_step, 1'b0);
        end
      end
      StRdA: begin
        busy_d = 1'b1;
        if (terminal) begin
          // Descending phases start from the address we just finished on.
          state_d = StWrB;
          wr_d    = 1'b1;
          data_d  = word(addr_q, 1'b1);
        end else begin
          addr_d = addr_step;
          rd_d   = 1'b1;
        end
      end
      StWrB: begin
        busy_d = 1'b1;
        addr_d = addr_step;
        if (terminal) begin
          state_d = StRdB;
          rd_d    = 1'b1;
        end else begin
          wr_d   = 1'b1;
          data_d = word(addr_step, 1'b1);
        end
      end
      StRdB: begin
        busy_d = 1'b1;
        if (terminal) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_step;
          rd_d   = 1'b1;
        end
      end
      StDrain: begin
        // The final read is compared this cycle, so fold it into pass.
        state_d = StDone;
        done_d  = 1'b1;
        pass_d  = !(err || new_fail);
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    if (busy_q && new_fail) begin
      state_d = StDone;
      addr_d  = '0;
      data_d  = '0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_q;
  assign mem_wr_en   = wr_q;
  assign mem_rd_en   = rd_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a behavioural RAM that can corrupt reads of one address.
module tb_ram_bist_ctrl;

  localparam int          N       = 16;
  localparam int          NCYC    = 72;
  localparam logic [7:0]  PATTERN = 8'hA5;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [3:0] fail_addr, mem_addr;
  logic [7:0] fail_exp, fail_got, mem_data_in, mem_data_out;
  logic       mem_wr_en, mem_rd_en;

  ram_bist_ctrl #(
    .WIDTH  (8),
    .DEPTH  (4),
    .PATTERN(PATTERN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_addr   (fail_addr),
    .fail_exp    (fail_exp),
    .fail_got    (fail_got),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM with an optional read fault: data from f_addr comes back xored with f_mask.
  logic       f_en = 1'b0;
  logic [3:0] f_addr = 4'h0;
  logic [7:0] f_mask = 8'h00;
  logic [7:0] ram [16];

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= ram[mem_addr] ^ ((f_en && mem_addr == f_addr) ? f_mask : 8'h00);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    else n_pass++;
  endtask

  // Per-cycle expectations, cycle 0 being the one in which start is driven.
  logic       m_busy [NCYC];
  logic       m_done [NCYC];
  logic       m_pass [NCYC];
  logic       m_wr   [NCYC];
  logic       m_rd   [NCYC];
  logic [3:0] m_addr [NCYC];
  logic [7:0] m_din  [NCYC];
  logic [3:0] m_fa   [NCYC];
  logic [7:0] m_fe   [NCYC];
  logic [7:0] m_fg   [NCYC];

  logic [7:0] s_din  [NCYC];
  logic [3:0] s_addr [NCYC];
  int         both_cnt;
  int         first_done;

  task automatic build_model(input bit fe, input logic [3:0] fa, input logic [7:0] fm);
    logic [7:0] mm [16];
    bit         found;
    int         fc, done_c, c;
    logic [3:0] a, f_a;
    logic [7:0] d, got, f_e, f_g;
    found = 1'b0;
    fc = 0;
    f_a = '0;
    f_e = '0;
    f_g = '0;
    for (int i = 0; i < NCYC; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
      m_addr[i] = '0; m_din[i] = '0; m_fa[i] = '0; m_fe[i] = '0; m_fg[i] = '0;
    end
    // Four phases of N accesses: ascending pair, then descending inverted pair.
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < N; j++) begin
        c = 1 + p * N + j;
        a = (p < 2) ? 4'(j) : 4'(N - 1 - j);
        d = PATTERN ^ {4'h0, a};
        if (p >= 2) d = ~d;
        m_addr[c] = a;
        if (p % 2 == 0) begin
          m_wr[c]  = 1'b1;
          m_din[c] = d;
          mm[a]    = d;
        end else begin
          m_rd[c] = 1'b1;
          got = mm[a] ^ ((fe && a == fa) ? fm : 8'h00);
          if (!found && got !== d) begin
            found = 1'b1;
            fc    = c + 2;
            f_a   = a;
            f_e   = d;
            f_g   = got;
          end
        end
      end
    end
    done_c = 4 * N + 2;
    if (STOP && found) done_c = fc;
    for (int i = 1; i < NCYC; i++) begin
      if (i < done_c) m_busy[i] = 1'b1;
      else begin
        m_done[i] = 1'b1;
        m_pass[i] = !found;
        m_wr[i]   = 1'b0;
        m_rd[i]   = 1'b0;
      end
      if (found && i >= fc) begin
        m_fa[i] = f_a;
        m_fe[i] = f_e;
        m_fg[i] = f_g;
      end
    end
  endtask

  task automatic run_model(input bit fe, input logic [3:0] fa, input logic [7:0] fm,
                           input int ign);
    build_model(fe, fa, fm);
    f_en   = fe;
    f_addr = fa;
    f_mask = fm;
    both_cnt   = 0;
    first_done = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < NCYC; k++) begin
      @(negedge clk);
      start = (k == ign);
      s_din[k]  = mem_data_in;
      s_addr[k] = mem_addr;
      if (mem_wr_en && mem_rd_en) both_cnt++;
      if (done && first_done < 0) first_done = k;
      chk("busy", k, busy, m_busy[k]);
      chk("done", k, done, m_done[k]);
      chk("pass", k, pass, m_pass[k]);
      chk("wr_en", k, mem_wr_en, m_wr[k]);
      chk("rd_en", k, mem_rd_en, m_rd[k]);
      if (m_wr[k] || m_rd[k]) chk("mem_addr", k, mem_addr, m_addr[k]);
      if (m_wr[k]) chk("data_in", k, mem_data_in, m_din[k]);
      chk("fail_addr", k, fail_addr, m_fa[k]);
      chk("fail_exp", k, fail_exp, m_fe[k]);
      chk("fail_got", k, fail_got, m_fg[k]);
    end
    start = 1'b0;
  endtask

  typedef struct {
    bit         fe;
    logic [3:0] fa;
    logic [7:0] fm;
    int         ign;
    bit         pass_exp;
    logic [3:0] addr_exp;
    logic [7:0] exp_exp;
    logic [7:0] got_exp;
    int         done_free;
    int         done_stop;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit         rfe;
    logic [3:0] rfa;
    logic [7:0] rfm;
    int         done_exp;

    vecs[0] = '{fe: 0, fa: 4'd0,  fm: 8'h00, ign: 10, pass_exp: 1, addr_exp: 4'd0,
                exp_exp: 8'h00, got_exp: 8'h00, done_free: 66, done_stop: 66};
    vecs[1] = '{fe: 1, fa: 4'd9,  fm: 8'h01, ign: -1, pass_exp: 0, addr_exp: 4'd9,
                exp_exp: 8'hAC, got_exp: 8'hAD, done_free: 66, done_stop: 28};
    vecs[2] = '{fe: 1, fa: 4'd0,  fm: 8'h80, ign: -1, pass_exp: 0, addr_exp: 4'd0,
                exp_exp: 8'hA5, got_exp: 8'h25, done_free: 66, done_stop: 19};
    vecs[3] = '{fe: 1, fa: 4'd15, fm: 8'hFF, ign: -1, pass_exp: 0, addr_exp: 4'd15,
                exp_exp: 8'hAA, got_exp: 8'h55, done_free: 66, done_stop: 34};
    vecs[4] = '{fe: 1, fa: 4'd6,  fm: 8'h5A, ign: -1, pass_exp: 0, addr_exp: 4'd6,
                exp_exp: 8'hA3, got_exp: 8'hF9, done_free: 66, done_stop: 25};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.busy", 0, busy, 0);
    chk("rst.done", 0, done, 0);
    chk("rst.pass", 0, pass, 0);
    chk("rst.wr_en", 0, mem_wr_en, 0);
    chk("rst.rd_en", 0, mem_rd_en, 0);
    chk("rst.fail_addr", 0, fail_addr, 0);
    chk("rst.fail_exp", 0, fail_exp, 0);
    chk("rst.fail_got", 0, fail_got, 0);
    rst = 1'b0;

    // Table runs back to back, so each later run also starts from DONE.
    for (int i = 0; i < 5; i++) begin
      run_model(vecs[i].fe, vecs[i].fa, vecs[i].fm, vecs[i].ign);
      done_exp = STOP ? vecs[i].done_stop : vecs[i].done_free;
      chk($sformatf("v%0d.done_cycle", i), first_done, first_done, done_exp);
      chk($sformatf("v%0d.pass", i), NCYC - 1, pass, vecs[i].pass_exp);
      chk($sformatf("v%0d.fail_addr", i), NCYC - 1, fail_addr, vecs[i].addr_exp);
      chk($sformatf("v%0d.fail_exp", i), NCYC - 1, fail_exp, vecs[i].exp_exp);
      chk($sformatf("v%0d.fail_got", i), NCYC - 1, fail_got, vecs[i].got_exp);
      chk($sformatf("v%0d.wr_rd_overlap", i), -1, both_cnt, 0);
      if (i == 0) begin
        chk("wr_a.addr3", 4, s_addr[4], 4'd3);
        chk("wr_a.data3", 4, s_din[4], 8'hA6);
        chk("wr_b.addr3", 45, s_addr[45], 4'd3);
        chk("wr_b.data3", 45, s_din[45], 8'h59);
      end
    end

    // Reset in the middle of a run.
    f_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst.busy_before", 20, busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 21, busy, 0);
    chk("midrst.done", 21, done, 0);
    chk("midrst.pass", 21, pass, 0);
    chk("midrst.wr_en", 21, mem_wr_en, 0);
    chk("midrst.rd_en", 21, mem_rd_en, 0);
    chk("midrst.addr", 21, mem_addr, 0);
    chk("midrst.data_in", 21, mem_data_in, 0);
    chk("midrst.fail_addr", 21, fail_addr, 0);
    @(negedge clk);
    chk("midrst.idle_busy", 22, busy, 0);
    chk("midrst.idle_wr", 22, mem_wr_en, 0);
    chk("midrst.idle_rd", 22, mem_rd_en, 0);
    run_model(1'b0, 4'd0, 8'h00, -1);
    chk("midrst.rerun_pass", NCYC - 1, pass, 1);

    // Random single-address read faults.
    for (int r = 0; r < 6; r++) begin
      rfe = ($urandom_range(0, 3) != 0);
      rfa = 4'($urandom_range(0, 15));
      rfm = 8'($urandom_range(1, 255));
      run_model(rfe, rfa, rfm, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
